// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one column low at a time, classifies each
// whole scan frame, debounces a single key over frames and offers it via valid/ack.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 5000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       CLK,
  input  logic       clear_n,
  input  logic [3:0] KEY_ROW,
  output logic [3:0] KEY_COL,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overrun
);

  localparam logic [15:0] DwellMax = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DebCnt   = 4'(DEBOUNCE);

  typedef enum logic [1:0] {ResNone, ResSingle, ResMulti} res_e;
  typedef enum logic [1:0] {StIdle, StDeb, StHeld, StRel} state_e;

  logic [3:0]  row_s1_q, row_s2_q;
  logic [15:0] dwell_q, dwell_d;
  logic [1:0]  col_q, col_d;
  logic [3:0]  key_col_q;
  logic        sample;

  logic [3:0]  lows;
  logic [2:0]  nlow, base_n, tot_n;
  logic [1:0]  row_idx;
  logic [1:0]  acc_n_q, acc_n_d;
  logic [3:0]  acc_code_q, acc_code_d;
  logic        frm_vld_q;
  res_e        frm_res_q, frm_res_d;
  logic [3:0]  frm_code_q;

  state_e      state_q, state_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  count_q, count_d;
  logic        report;

  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        overrun_q, overrun_d;
  logic        key_down_q, key_down_d;

  assign sample = (dwell_q == DwellMax);
  assign dwell_d = sample ? 16'd0 : dwell_q + 16'd1;
  assign col_d   = sample ? col_q + 2'd1 : col_q;

  // Per-column low-bit count, accumulated (saturating at 2) across the frame.
  always_comb begin
    lows    = ~row_s2_q;
    nlow    = {2'b0, lows[0]} + {2'b0, lows[1]} + {2'b0, lows[2]} + {2'b0, lows[3]};
    row_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (lows[i]) row_idx = 2'(i);
    end
    base_n     = (col_q == 2'd0) ? 3'd0 : {1'b0, acc_n_q};
    tot_n      = base_n + nlow;
    acc_n_d    = (tot_n > 3'd2) ? 2'd2 : tot_n[1:0];
    acc_code_d = (nlow == 3'd1) ? {col_q, row_idx} : acc_code_q;
    unique case (acc_n_d)
      2'd0:    frm_res_d = ResNone;
      2'd1:    frm_res_d = ResSingle;
      default: frm_res_d = ResMulti;
    endcase
  end

  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      row_s1_q   <= 4'hF;
      row_s2_q   <= 4'hF;
      dwell_q    <= 16'd0;
      col_q      <= 2'd0;
      key_col_q  <= 4'b1110;
      acc_n_q    <= 2'd0;
      acc_code_q <= 4'd0;
      frm_vld_q  <= 1'b0;
      frm_res_q  <= ResNone;
      frm_code_q <= 4'd0;
    end else begin
      row_s1_q  <= KEY_ROW;
      row_s2_q  <= row_s1_q;
      dwell_q   <= dwell_d;
      col_q     <= col_d;
      key_col_q <= ~(4'b0001 << col_d);
      frm_vld_q <= sample && (col_q == 2'd3);
      if (sample) begin
        acc_n_q    <= acc_n_d;
        acc_code_q <= acc_code_d;
        if (col_q == 2'd3) begin
          frm_res_q  <= frm_res_d;
          frm_code_q <= acc_code_d;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    count_d = count_q;
    report  = 1'b0;
    if (frm_vld_q) begin
      unique case (state_q)
        StIdle: begin
          if (frm_res_q == ResSingle) begin
            cand_d  = frm_code_q;
            count_d = 4'd1;
            if (DebCnt == 4'd1) begin
              report  = 1'b1;
              state_d = StHeld;
            end else begin
              state_d = StDeb;
            end
          end
        end
        StDeb: begin
          if (frm_res_q == ResSingle) begin
            if (frm_code_q == cand_q) begin
              count_d = count_q + 4'd1;
              if (count_d == DebCnt) begin
                report  = 1'b1;
                state_d = StHeld;
              end
            end else begin
              cand_d  = frm_code_q;
              count_d = 4'd1;
            end
          end else begin
            state_d = StIdle;
          end
        end
        StHeld: begin
          if (frm_res_q == ResNone) begin
            count_d = 4'd1;
            state_d = (DebCnt == 4'd1) ? StIdle : StRel;
          end
        end
        StRel: begin
          if (frm_res_q == ResNone) begin
            count_d = count_q + 4'd1;
            if (count_d == DebCnt) state_d = StIdle;
          end else begin
            state_d = StHeld;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A report wins over a same-cycle consume; a report onto an unconsumed key is dropped.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (report) begin
      if (!key_valid_q || key_ack) begin
        key_code_d  = cand_d;
        key_valid_d = 1'b1;
        if (key_ack && key_valid_q) overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_ack && key_valid_q) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
    key_down_d = (state_d == StHeld) || (state_d == StRel);
  end

  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= StIdle;
      cand_q      <= 4'd0;
      count_q     <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      count_q     <= count_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
      key_down_q  <= key_down_d;
    end
  end

  assign KEY_COL   = key_col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a pressed-key set drives the matrix, and a frame-level
// run-length model of press/release acceptance predicts every registered output.
module tb_keypad_scanner;

  localparam int Deb = 3;

  logic        CLK = 1'b0;
  logic        clear_n;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack;
  logic        key_down;
  logic        overrun;

  logic [15:0] pressed;
  int          checks = 0;
  int          errors = 0;

  // Model state: held flag plus run lengths of identical single-key / empty frames.
  bit          m_held;
  int          m_srun, m_skey, m_nrun;
  bit          m_valid, m_over;
  logic [3:0]  m_code;
  logic [15:0] prev_keys;
  bit          have_prev;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(Deb)) dut (
    .CLK      (CLK),
    .clear_n  (clear_n),
    .KEY_ROW  (key_row),
    .KEY_COL  (key_col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ack  (key_ack),
    .key_down (key_down),
    .overrun  (overrun)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    key_row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pressed[c*4+r] && !key_col[c]) key_row[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, {15'd0, key_valid}, {15'd0, m_valid});
    chk({tag, "_code"}, {12'd0, key_code}, {12'd0, m_code});
    chk({tag, "_down"}, {15'd0, key_down}, {15'd0, m_held});
    chk({tag, "_overrun"}, {15'd0, overrun}, {15'd0, m_over});
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_col"}, {12'd0, key_col}, 16'h000E);
    chk({tag, "_valid"}, {15'd0, key_valid}, 16'd0);
    chk({tag, "_code"}, {12'd0, key_code}, 16'd0);
    chk({tag, "_down"}, {15'd0, key_down}, 16'd0);
    chk({tag, "_overrun"}, {15'd0, overrun}, 16'd0);
  endtask

  task automatic model_reset();
    m_held = 0; m_srun = 0; m_skey = 0; m_nrun = 0;
    m_valid = 0; m_over = 0; m_code = 4'd0;
    prev_keys = 16'd0; have_prev = 0;
  endtask

  task automatic model_step(input bit have_frame, input logic [15:0] keys, input bit ack);
    bit report;
    int n;
    int k;
    report = 0;
    n = $countones(keys);
    k = 0;
    for (int i = 0; i < 16; i++) if (keys[i]) k = i;
    if (have_frame) begin
      if (m_held) begin
        if (n == 0) begin
          m_nrun++;
          if (m_nrun >= Deb) begin m_held = 0; m_srun = 0; end
        end else begin
          m_nrun = 0;
        end
      end else if (n == 1) begin
        if (m_srun > 0 && m_skey == k) m_srun++;
        else begin m_skey = k; m_srun = 1; end
        if (m_srun == Deb) begin report = 1; m_held = 1; m_nrun = 0; m_srun = 0; end
      end else begin
        m_srun = 0;
      end
    end
    if (report) begin
      if (!m_valid || ack) begin
        if (ack && m_valid) m_over = 0;
        m_code = 4'(m_skey);
        m_valid = 1;
      end else begin
        m_over = 1;
      end
    end else if (ack && m_valid) begin
      m_valid = 0;
      m_over = 0;
    end
  endtask

  // Called at the start of a frame; the ack lands on the cycle that processes the previous frame.
  task automatic do_frame(input logic [15:0] keys, input bit ack);
    logic [3:0] exp_col;
    check_outputs("pre");
    pressed = keys;
    key_ack = ack;
    model_step(have_prev, prev_keys, ack);
    prev_keys = keys;
    have_prev = 1;
    for (int j = 1; j <= 16; j++) begin
      @(posedge CLK); #1;
      if (j == 1) begin
        key_ack = 1'b0;
        check_outputs("post");
      end
      exp_col = ~(4'b0001 << ((j / 4) % 4));
      chk("key_col", {12'd0, key_col}, {12'd0, exp_col});
    end
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) do_frame(16'd0, 1'b0);
  endtask

  initial begin
    logic [15:0] keys;
    int r;
    clear_n = 1'b0;
    key_ack = 1'b0;
    pressed = 16'd0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1 check_reset_values("rst");
    @(negedge CLK) clear_n = 1'b1;

    // Idle scanning, no key ever reported.
    idle_frames(3);

    // Clean press of key 9 (row 1, column 2).
    for (int i = 0; i < 3; i++) do_frame(16'h1 << 9, 1'b0);
    do_frame(16'h1 << 9, 1'b0);
    chk("press_code", {12'd0, key_code}, 16'd9);
    chk("press_valid", {15'd0, key_valid}, 16'd1);
    do_frame(16'h1 << 9, 1'b1);
    chk("ack_valid", {15'd0, key_valid}, 16'd0);
    idle_frames(3);
    do_frame(16'd0, 1'b0);
    chk("release_down", {15'd0, key_down}, 16'd0);

    // Bounce: 2 present, 1 absent, 2 present.
    do_frame(16'h1 << 9, 1'b0);
    do_frame(16'h1 << 9, 1'b0);
    do_frame(16'd0, 1'b0);
    do_frame(16'h1 << 9, 1'b0);
    do_frame(16'h1 << 9, 1'b0);
    idle_frames(2);
    chk("bounce_valid", {15'd0, key_valid}, 16'd0);

    // Multi-key 0+5, then only 5.
    for (int i = 0; i < 3; i++) do_frame(16'h0021, 1'b0);
    for (int i = 0; i < 3; i++) do_frame(16'h0020, 1'b0);
    do_frame(16'h0020, 1'b0);
    chk("multi_code", {12'd0, key_code}, 16'd5);
    do_frame(16'h0020, 1'b1);
    idle_frames(4);

    // Overrun: key 3 unconsumed, then key 7.
    for (int i = 0; i < 3; i++) do_frame(16'h1 << 3, 1'b0);
    idle_frames(3);
    for (int i = 0; i < 3; i++) do_frame(16'h1 << 7, 1'b0);
    do_frame(16'd0, 1'b0);
    chk("ovr_code", {12'd0, key_code}, 16'd3);
    chk("ovr_flag", {15'd0, overrun}, 16'd1);
    do_frame(16'd0, 1'b1);
    chk("ovr_ack_valid", {15'd0, key_valid}, 16'd0);
    chk("ovr_ack_flag", {15'd0, overrun}, 16'd0);
    idle_frames(3);

    // Reset in the middle of the 2nd debounce frame of key 9.
    do_frame(16'h1 << 9, 1'b0);
    pressed = 16'h1 << 9;
    repeat (6) @(posedge CLK);
    #1 clear_n = 1'b0;
    #1 check_reset_values("midrst");
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK) clear_n = 1'b1;
    for (int i = 0; i < 3; i++) do_frame(16'h1 << 9, 1'b0);
    chk("midrst_early", {15'd0, key_valid}, 16'd0);
    do_frame(16'h1 << 9, 1'b0);
    chk("midrst_valid", {15'd0, key_valid}, 16'd1);
    do_frame(16'h1 << 9, 1'b1);
    idle_frames(3);

    // Randomized frames with sticky key sets and random acks.
    keys = 16'd0;
    for (int f = 0; f < 80; f++) begin
      r = $urandom_range(0, 99);
      if (r < 55) keys = keys;
      else if (r < 70) keys = 16'd0;
      else if (r < 92) keys = 16'h1 << $urandom_range(0, 15);
      else keys = 16'($urandom);
      do_frame(keys, ($urandom_range(0, 3) == 0));
    end
    idle_frames(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Reads the board's 4x4 matrix keypad, the input-side counterpart of the LED-matrix and 7-segment scan drivers. The block drives one column strobe low at a time and samples the pulled-up row lines. It debounces a single pressed key over whole scan frames and presents its code to the game logic through a valid/ack handshake. The game FSM uses it as a richer input source than discrete Left/Right buttons: direction, mode select and restart.

## Interface
- SCAN_DIV, default 5000: CLK cycles each column is strobed; legal range 4..65535.
- DEBOUNCE, default 4: consecutive identical frames needed to accept a press or a release; legal range 1..15.

- CLK  in  1  system clock
- clear_n  in  1  asynchronous active-low reset
- KEY_ROW  in  4  row lines, active-low, asynchronous to CLK
- KEY_COL  out  4  column strobes, active-low one-hot
- key_code  out  4  accepted key, equal to col*4 + row
- key_valid  out  1  key_code holds an unconsumed key
- key_ack  in  1  consumer takes key_code
- key_down  out  1  debounced "some key held" level
- overrun  out  1  sticky: a key was accepted while key_valid=1 and was dropped

## Operation
- KEY_ROW passes through a 2-flop synchronizer before any use.
- A dwell counter runs 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps and the column index advances 0→1→2→3→0.
- KEY_COL = ~(1<<col).
- The synchronized rows are sampled on the dwell==SCAN_DIV-1 cycle of each column.
- Frame = columns 0..3. Frame result is one of:
  - NONE: no low bits seen.
  - SINGLE(k): exactly one low bit in exactly one column; k = col*4 + row bit index.
  - MULTI: anything else.
- The frame result is evaluated on the cycle column 3 is sampled. The FSM updates on the next cycle.
- FSM (count is 4 bits):
  - IDLE:
    - SINGLE(k) → cand=k, count=1. Report immediately if DEBOUNCE==1, otherwise go to DEB.
    - NONE or MULTI → stay.
  - DEB:
    - SINGLE(cand) → count++. At count==DEBOUNCE, report cand and go to HELD.
    - SINGLE(j≠cand) → cand=j, count=1, stay in DEB.
    - NONE or MULTI → IDLE.
  - HELD:
    - NONE → count=1. Go to IDLE if DEBOUNCE==1, else go to REL.
    - Any other result → stay.
  - REL:
    - NONE → count++. At count==DEBOUNCE go to IDLE.
    - SINGLE or MULTI → HELD.
- key_down = 1 in HELD and REL.
- Report rule, applied in the report cycle:
  - key_valid=0, or key_ack=1 in the same cycle → key_code←cand and key_valid←1. overrun is unchanged unless key_ack also clears it.
  - key_valid=1 and key_ack=0 → key_code is unchanged and overrun←1.
- Consumption: key_ack=1 while key_valid=1 clears key_valid and overrun on the next edge, unless a report occurs in that same cycle.
- key_ack while key_valid=0 is ignored.

## Timing
- Reset values:
  - KEY_COL=4'b1110, key_code=0, key_valid=0, key_down=0, overrun=0.
  - FSM=IDLE, count=0, col=0, dwell=0, synchronizer flops=4'b1111.
- Reset is asynchronous and takes effect mid-frame or mid-debounce. After release, scanning restarts at column 0 with dwell 0, and partial debounce progress is lost.
- Frame length is 4*SCAN_DIV cycles.
- Sampling happens SCAN_DIV-1 cycles after the strobe change, which covers settling plus synchronizer delay.
- Acceptance latency: key_valid rises 1 cycle after the end of the DEBOUNCE-th consecutive SINGLE(k) frame.
- key_valid falls 1 cycle after ack.
- All outputs are registered. No combinational path exists from KEY_ROW or key_ack to any output.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=3; frame = 16 cycles.
- Reset/scan: hold clear_n=0, then release, no keys pressed → all outputs at reset values. KEY_COL steps 1110→1101→1011→0111→1110 every 4 cycles. key_valid never asserts.
- Clean press: model key row1/col2 (KEY_ROW=1101 while KEY_COL=1011) from a frame start → key_valid=1, key_code=9, key_down=1 exactly 1 cycle after the 3rd frame ends. Pulse key_ack → key_valid=0 the next cycle. Release → key_down=0 after 3 NONE frames.
- Bounce: key 9 present for 2 frames, absent 1 frame, present 2 frames → no key_valid.
- Multi-key: keys 0 and 5 held together → no report. Then release key 0 → key_code=5 reported after 3 further frames.
- Overrun: press/release key 3 with no ack, then press key 7 → key_code stays 3, overrun=1. Ack → key_valid=0 and overrun=0 the next cycle.
- Reset mid-debounce: assert clear_n=0 during the 2nd frame of key 9 and release → outputs at reset values. key_valid rises only after 3 full frames counted from the restart.
